// File: rtl/shift_register_universal_if.sv
// Bus interface for shift_register_universal: serial/parallel data, control
// and status. Optional parity output exists only when SHIFT_PARITY_EN is defined.
interface shift_register_universal_if #(
    parameter int WIDTH = 24
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             Ser_In;
    logic [WIDTH-1:0] Par_In;
    logic             Par_load;
    logic             shift_en;
    logic [1:0]       mode;
    logic             start;
    logic [CNT_W-1:0] shift_len;
    logic [WIDTH-1:0] Par_out;
    logic             Ser_Out;
    logic             busy;
    logic             done;
`ifdef SHIFT_PARITY_EN
    logic             parity;
`endif

    // Driver side (stimulus / upstream logic)
    modport master (
        output Ser_In, Par_In, Par_load, shift_en, mode, start, shift_len,
`ifdef SHIFT_PARITY_EN
        input  parity,
`endif
        input  Par_out, Ser_Out, busy, done
    );

    // Register side
    modport slave (
        input  Ser_In, Par_In, Par_load, shift_en, mode, start, shift_len,
`ifdef SHIFT_PARITY_EN
        output parity,
`endif
        output Par_out, Ser_Out, busy, done
    );
endinterface

// File: rtl/shift_register_universal.sv
// Universal shift register: shift/rotate left/right, single-step shift and a
// self-timed burst engine (load length once, shift N times, one-cycle done).
// Optional feature macro: SHIFT_PARITY_EN adds a combinational parity output.
module shift_register_universal #(
    parameter int WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    shift_register_universal_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shifted;

    // One-step shift result for the currently selected mode
    always_comb begin
        shifted = reg_q;
        unique case (bus.mode)
            2'b00:   shifted = {reg_q[WIDTH-2:0], bus.Ser_In};
            2'b01:   shifted = {bus.Ser_In, reg_q[WIDTH-1:1]};
            2'b10:   shifted = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
            default: shifted = {reg_q[0], reg_q[WIDTH-1:1]};
        endcase
    end

    // Next state: load > burst shift > start > single-step shift
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (bus.Par_load) begin
            // Load aborts any running burst silently.
            reg_d   = bus.Par_In;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            reg_d = shifted;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (bus.start) begin
            if (bus.shift_len == '0) begin
                done_d = 1'b1;
            end else begin
                cnt_d   = bus.shift_len;
                state_d = SHIFT;
            end
        end else if (bus.shift_en) begin
            reg_d = shifted;
        end
    end

    // State, data and counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.Par_out = reg_q;
    assign bus.Ser_Out = bus.mode[0] ? reg_q[0] : reg_q[WIDTH-1];
    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;

`ifdef SHIFT_PARITY_EN
    assign bus.parity  = ^reg_q;
`endif

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal (WIDTH=24) with a scoreboard queue.
module tb_shift_register_universal;
    localparam int WIDTH = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_register_universal_if #(.WIDTH(WIDTH)) sr_if ();

    shift_register_universal #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sr_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        sr_if.Par_In   = v;
        sr_if.Par_load = 1'b1;
        tick();
        sr_if.Par_load = 1'b0;
        push("load_par_out", 32'(v));
        pop_check(32'(sr_if.Par_out));
    endtask

    // Launch a burst of len>0 shifts and check cycle count, final value, done width.
    task automatic burst(input string tag, input logic [4:0] len, input logic [WIDTH-1:0] fin);
        int cyc;
        sr_if.shift_len = len;
        sr_if.start     = 1'b1;
        push({tag, "_busy_start"}, 32'd1);
        push({tag, "_noshift_start"}, 32'(sr_if.Par_out));
        tick();
        sr_if.start = 1'b0;
        pop_check(32'(sr_if.busy));
        pop_check(32'(sr_if.Par_out));
        push({tag, "_len"}, 32'(len));
        push({tag, "_final"}, 32'(fin));
        push({tag, "_busy_end"}, 32'd0);
        push({tag, "_done_width"}, 32'd0);
        cyc = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (sr_if.done || !sr_if.busy) break;
        end
        pop_check(32'(cyc));
        pop_check(32'(sr_if.Par_out));
        pop_check(32'(sr_if.busy));
        tick();
        pop_check(32'(sr_if.done));
    endtask

    initial begin
        logic [4:0] ser_exp;
        sr_if.Ser_In    = 1'b0;
        sr_if.Par_In    = '0;
        sr_if.Par_load  = 1'b0;
        sr_if.shift_en  = 1'b0;
        sr_if.mode      = 2'b00;
        sr_if.start     = 1'b0;
        sr_if.shift_len = '0;

        // Reset state
        #12;
        push("rst_par_out", 32'd0);
        push("rst_busy", 32'd0);
        push("rst_done", 32'd0);
        pop_check(32'(sr_if.Par_out));
        pop_check(32'(sr_if.busy));
        pop_check(32'(sr_if.done));
`ifdef SHIFT_PARITY_EN
        push("rst_parity", 32'd0);
        pop_check(32'(sr_if.parity));
`endif
        rst = 1'b0;

        // Shift left with Ser_In=1, checking Ser_Out before each step
        load(24'hA5A5A5);
        sr_if.mode     = 2'b00;
        sr_if.Ser_In   = 1'b1;
        ser_exp        = 5'b10100;
        for (int i = 0; i < 5; i++) begin
            push($sformatf("shl_ser_out_%0d", i), 32'(ser_exp[4-i]));
            pop_check(32'(sr_if.Ser_Out));
            sr_if.shift_en = 1'b1;
            tick();
        end
        sr_if.shift_en = 1'b0;
        push("shl_par_out", 32'h00B4B4BF);
        push("shl_done_idle", 32'd0);
        pop_check(32'(sr_if.Par_out));
        pop_check(32'(sr_if.done));

        // Shift right with Ser_In=0
        load(24'hA5A5A5);
        sr_if.mode   = 2'b01;
        sr_if.Ser_In = 1'b0;
        push("shr_ser_out", 32'd1);
        pop_check(32'(sr_if.Ser_Out));
        sr_if.shift_en = 1'b1;
        repeat (4) tick();
        sr_if.shift_en = 1'b0;
        push("shr_par_out", 32'h000A5A5A);
        pop_check(32'(sr_if.Par_out));

        // Rotate-right burst of 8; start/shift_en raised mid-burst are ignored
        load(24'h123456);
        sr_if.mode = 2'b11;
        push("ror_ser_out", 32'd0);
        pop_check(32'(sr_if.Ser_Out));
        fork
            burst("ror8", 5'd8, 24'h561234);
            begin
                repeat (3) @(posedge clk);
                #2;
                sr_if.start    = 1'b1;
                sr_if.shift_en = 1'b1;
                @(posedge clk);
                #2;
                sr_if.start    = 1'b0;
                sr_if.shift_en = 1'b0;
            end
        join

        // Async reset mid rotate-left burst
        load(24'h123456);
        sr_if.mode      = 2'b10;
        sr_if.shift_len = 5'd4;
        sr_if.start     = 1'b1;
        tick();
        sr_if.start = 1'b0;
        tick();
        tick();
        push("rol2_par_out", 32'h0048D158);
        pop_check(32'(sr_if.Par_out));
        #2 rst = 1'b1;
        #1;
        push("async_rst_par_out", 32'd0);
        push("async_rst_busy", 32'd0);
        pop_check(32'(sr_if.Par_out));
        pop_check(32'(sr_if.busy));
        #3 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            push($sformatf("post_rst_done_%0d", i), 32'd0);
            push($sformatf("post_rst_busy_%0d", i), 32'd0);
            pop_check(32'(sr_if.done));
            pop_check(32'(sr_if.busy));
        end
        push("post_rst_par_out", 32'd0);
        pop_check(32'(sr_if.Par_out));

        // Par_load aborts a burst of 10 at the 3rd shift edge
        load(24'h123456);
        sr_if.mode      = 2'b00;
        sr_if.Ser_In    = 1'b1;
        sr_if.shift_len = 5'd10;
        sr_if.start     = 1'b1;
        tick();
        sr_if.start = 1'b0;
        tick();
        tick();
        sr_if.Par_In   = 24'hFFFFFF;
        sr_if.Par_load = 1'b1;
        tick();
        sr_if.Par_load = 1'b0;
        push("abort_par_out", 32'h00FFFFFF);
        push("abort_busy", 32'd0);
        push("abort_done", 32'd0);
        pop_check(32'(sr_if.Par_out));
        pop_check(32'(sr_if.busy));
        pop_check(32'(sr_if.done));
        for (int i = 0; i < 12; i++) begin
            tick();
            push($sformatf("abort_no_done_%0d", i), 32'd0);
            pop_check(32'(sr_if.done));
        end

        // Zero-length start: done pulse only
        sr_if.shift_len = 5'd0;
        sr_if.start     = 1'b1;
        tick();
        sr_if.start = 1'b0;
        push("len0_done", 32'd1);
        push("len0_busy", 32'd0);
        push("len0_par_out", 32'h00FFFFFF);
        pop_check(32'(sr_if.done));
        pop_check(32'(sr_if.busy));
        pop_check(32'(sr_if.Par_out));
        tick();
        push("len0_done_clear", 32'd0);
        push("len0_par_out_hold", 32'h00FFFFFF);
        pop_check(32'(sr_if.done));
        pop_check(32'(sr_if.Par_out));

        // Start and Par_load on the same edge: load wins
        sr_if.Par_In    = 24'h0F0F0F;
        sr_if.Par_load  = 1'b1;
        sr_if.start     = 1'b1;
        sr_if.shift_len = 5'd5;
        tick();
        sr_if.Par_load = 1'b0;
        sr_if.start    = 1'b0;
        push("ld_start_par_out", 32'h000F0F0F);
        push("ld_start_busy", 32'd0);
        pop_check(32'(sr_if.Par_out));
        pop_check(32'(sr_if.busy));
        tick();
        push("ld_start_no_done", 32'd0);
        push("ld_start_hold", 32'h000F0F0F);
        pop_check(32'(sr_if.done));
        pop_check(32'(sr_if.Par_out));

        // Bursts longer than WIDTH
        load(24'h000000);
        sr_if.mode   = 2'b01;
        sr_if.Ser_In = 1'b1;
        burst("shr30", 5'd30, 24'hFFFFFF);
        load(24'h123456);
        sr_if.mode = 2'b10;
        burst("rol25", 5'd25, 24'h2468AC);

`ifdef SHIFT_PARITY_EN
        load(24'hA5A5A5);
        push("par_a5", 32'd0);
        pop_check(32'(sr_if.parity));
        sr_if.mode     = 2'b00;
        sr_if.Ser_In   = 1'b1;
        sr_if.shift_en = 1'b1;
        tick();
        sr_if.shift_en = 1'b0;
        push("par_shl_val", 32'h004B4B4B);
        push("par_shl", 32'd0);
        pop_check(32'(sr_if.Par_out));
        pop_check(32'(sr_if.parity));
        load(24'h000001);
        push("par_one", 32'd1);
        pop_check(32'(sr_if.parity));
`endif

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
- Parametrised successor to the fixed-width 24/80-bit shift registers.
- Adds selectable direction and rotate modes, plus a self-timed burst-shift engine (load once, shift N bits automatically, done pulse).
- Used as the serialiser/deserialiser datapath feeding the serial links in the CA datapaths.

Parameters:
- WIDTH, 24, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1) (localparam, derived), width of the burst length and counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- Ser_In  input  1  serial input bit.
- Par_In  input  WIDTH  parallel load data.
- Par_load  input  1  synchronous parallel load.
- shift_en  input  1  single-step shift, applied when idle.
- mode  input  2  00 shift left, 01 shift right, 10 rotate left, 11 rotate right.
- start  input  1  begin burst, sampled only when idle.
- shift_len  input  CNT_W  number of burst shifts.
- Par_out  output  WIDTH  register contents.
- Ser_Out  output  1  outgoing bit (combinational from register and mode).
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst end.

Behaviour:
- Reset (async, immediate): Par_out = 0, busy = 0, done = 0, counter = 0. Any burst in progress is aborted and no done pulse is produced.
- Shift semantics per mode:
  - 00: reg <= {reg[W-2:0], Ser_In}; Ser_Out = reg[W-1].
  - 01: reg <= {Ser_In, reg[W-1:1]}; Ser_Out = reg[0].
  - 10: reg <= {reg[W-2:0], reg[W-1]}; Ser_Out = reg[W-1]. Ser_In is ignored.
  - 11: reg <= {reg[0], reg[W-1:1]}; Ser_Out = reg[0]. Ser_In is ignored.
- Priority each edge: Par_load > active burst shift > start > shift_en.
- Par_load: reg <= Par_In. If a burst is active, it is aborted (busy <= 0, no done pulse).
- Idle with shift_en = 1 and start = 0: one shift per edge.
- Burst states: IDLE, SHIFT.
  - IDLE, start = 1, shift_len = N > 0: counter <= N, busy <= 1, go to SHIFT. No shift on this edge.
  - SHIFT: each edge performs one shift and decrements the counter. On the edge that performs the Nth shift: busy <= 0, done <= 1, go to IDLE.
  - Timing: start sampled at edge k → shifts on edges k+1..k+N; done is high during the cycle after edge k+N.
- Boundaries:
  - start with shift_len = 0: no shift, busy stays 0, done pulses in the cycle after edge k.
  - start, shift_en or a changed mode while busy: start and shift_en are ignored. mode is sampled on every edge, so it must be held stable by the user during a burst.
  - shift_len > WIDTH: legal. Left/right modes shift in Ser_In for all N cycles; rotate modes wrap.
  - done is 0 in every cycle other than the single pulse.
  - start and Par_load on the same edge: load wins and start is dropped.

Optional Feature:
- Macro SHIFT_PARITY_EN.
- Defined: adds output port parity (1 bit) = XOR reduction of Par_out, combinational, 0 after reset.
- Undefined: port and logic absent; all other behaviour unchanged.

Test Plan:
- WIDTH=24: reset, load Par_In=24'hA5A5A5, mode=00, Ser_In=1, shift_en for 5 edges → Par_out=24'hB4B4BF; Ser_Out sequence before each shift = 1,0,1,0,0.
- Load 24'hA5A5A5, mode=01, Ser_In=0, shift_en for 4 edges → Par_out=24'h0A5A5A.
- Load 24'h123456, mode=11, start with shift_len=8 → busy high for 8 cycles, Par_out=24'h561234, done high exactly 1 cycle, then busy=0.
- Load 24'h123456, mode=10, start with shift_len=4, assert rst asynchronously after 2 shifts → Par_out=0, busy=0, done never pulses.
- During a burst (shift_len=10), assert Par_load with Par_In=24'hFFFFFF at the 3rd shift → Par_out=24'hFFFFFF, busy=0, no done; start with shift_len=0 → done pulse next cycle, Par_out unchanged.
- With SHIFT_PARITY_EN defined: load 24'hA5A5A5 → parity=0; shift left once with Ser_In=1 → Par_out=24'h4B4B4B, parity=0; load 24'h000001 → parity=1.
